// File: rtl/als_pkg.sv
// Shared frame geometry and FSM state encoding for the ALS SPI responder.
package als_pkg;

  localparam int unsigned FRAME_BITS  = 16;
  localparam int unsigned LEAD_ZEROS  = 3;
  localparam int unsigned TRAIL_ZEROS = 5;
  localparam int unsigned DATA_SLOT   = FRAME_BITS - LEAD_ZEROS - TRAIL_ZEROS;
  localparam int unsigned CNT_W       = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous input plus edge detection.
// level is the synchronized value; edge_c flags a change, direction given by level.
module sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic edge_c
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign level  = chain[STAGES-1];
  assign edge_c = chain[STAGES-1] ^ prev;

endmodule

// File: rtl/als_spi_responder.sv
// SPI read-only responder shipping a 16-bit light-sample frame, MSB first.
// Build option ALS_RESP_TEST_PATTERN_EN replaces the sample register with an incrementing pattern.
module als_spi_responder
  import als_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              cs,
  input  logic              scl,
  output logic              sdo,
  output logic              sdo_oe,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_abort
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(FRAME_BITS);

  logic cs_lvl, cs_edge, scl_lvl, scl_edge;
  logic cs_fall, cs_rise, scl_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .d      (cs),
    .level  (cs_lvl),
    .edge_c (cs_edge)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_scl_sync (
    .clk    (clk),
    .rst    (rst),
    .d      (scl),
    .level  (scl_lvl),
    .edge_c (scl_edge)
  );

  assign cs_fall  = cs_edge & ~cs_lvl;
  assign cs_rise  = cs_edge & cs_lvl;
  assign scl_fall = scl_edge & ~scl_lvl;

  state_t                state;
  logic [DATA_W-1:0]     hold;
  logic [FRAME_BITS-1:0] shreg;
  logic [CNT_W-1:0]      cnt;
  logic [FRAME_BITS-1:0] frame_c;

  assign frame_c = FRAME_BITS'(DATA_SLOT'(hold)) << TRAIL_ZEROS;

`ifdef ALS_RESP_TEST_PATTERN_EN
  logic unused_sample;
  assign unused_sample = ^{sample, sample_valid};

  // Pattern source advances once per completed frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold         <= '0;
      sample_ready <= 1'b0;
    end else begin
      sample_ready <= 1'b0;
      if (state == DONE) hold <= hold + DATA_W'(1);
    end
  end
`else
  // Holding register; the frame in flight works from its own snapshot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold         <= '0;
      sample_ready <= 1'b0;
    end else begin
      sample_ready <= 1'b1;
      if (sample_valid && sample_ready) hold <= sample;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      sdo         <= 1'b0;
      sdo_oe      <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state  <= SHIFT;
            shreg  <= frame_c;
            cnt    <= '0;
            sdo    <= frame_c[FRAME_BITS-1];
            sdo_oe <= 1'b1;
            busy   <= 1'b1;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state       <= (cnt == FULL) ? DONE : IDLE;
            frame_done  <= (cnt == FULL);
            frame_abort <= (cnt != FULL);
            sdo         <= 1'b0;
            sdo_oe      <= 1'b0;
            busy        <= 1'b0;
          end else if (scl_fall) begin
            // Zeros fill in behind, so edges past the frame end read 0.
            shreg <= shreg << 1;
            sdo   <= shreg[FRAME_BITS-2];
            if (cnt != FULL) cnt <= cnt + CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_als_spi_responder.sv
// Self-checking bench for als_spi_responder: table-driven SPI frames plus reset and mid-frame sequences.
module tb_als_spi_responder;

  localparam int unsigned DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic              sample_ready;
  logic              cs;
  logic              scl;
  logic              sdo;
  logic              sdo_oe;
  logic              busy;
  logic              frame_done;
  logic              frame_abort;

  always #5 clk = ~clk;

  als_spi_responder #(.SYNC_STAGES(2), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .cs           (cs),
    .scl          (scl),
    .sdo          (sdo),
    .sdo_oe       (sdo_oe),
    .busy         (busy),
    .frame_done   (frame_done),
    .frame_abort  (frame_abort)
  );

  int n_pass  = 0;
  int n_total = 0;

  int done_seen  = 0;
  int abort_seen = 0;

  always @(negedge clk) begin
    if (frame_done)  done_seen  = done_seen + 1;
    if (frame_abort) abort_seen = abort_seen + 1;
  end

  typedef struct {
    logic [31:0] bits;
    int          done;
    int          abort;
    string       name;
  } exp_t;

  typedef struct {
    logic        offer;
    logic [7:0]  smp;
    int          edges;
    logic [31:0] exp_bits;
    int          exp_done;
    int          exp_abort;
  } vec_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total = n_total + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic offer(input logic [7:0] v);
    @(posedge clk); #1;
    sample       = v;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
  endtask

  // Mode-0 master: scl idles low, data captured just before each rising edge.
  task automatic run_frame(input string name, input int edges, input int inject_at,
                           input logic [7:0] inject_val, output logic [31:0] acc,
                           output int ndone, output int nabort);
    int d0;
    int a0;
    acc = '0;
    d0  = done_seen;
    a0  = abort_seen;
    @(posedge clk); #1;
    cs = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check({name, "_oe_active"}, 32'(sdo_oe), 32'd1);
    check({name, "_busy_active"}, 32'(busy), 32'd1);
    for (int i = 0; i < edges; i++) begin
      if (i == inject_at) offer(inject_val);
      acc = {acc[30:0], sdo};
      scl = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      scl = 1'b0;
      repeat (8) @(posedge clk);
      #1;
    end
    cs = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check({name, "_oe_released"}, 32'(sdo_oe), 32'd0);
    check({name, "_busy_released"}, 32'(busy), 32'd0);
    check({name, "_sdo_idle"}, 32'(sdo), 32'd0);
    ndone  = done_seen - d0;
    nabort = abort_seen - a0;
  endtask

  task automatic do_frame(input string name, input int edges, input int inject_at,
                          input logic [7:0] inject_val, input logic [31:0] exp_bits,
                          input int exp_done, input int exp_abort);
    exp_t        e;
    logic [31:0] got;
    int          nd;
    int          na;
    e.bits  = exp_bits;
    e.done  = exp_done;
    e.abort = exp_abort;
    e.name  = name;
    sb.push_back(e);
    run_frame(name, edges, inject_at, inject_val, got, nd, na);
    if (sb.size() == 0) begin
      check({name, "_scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({e.name, "_bits"}, got, e.bits);
      check({e.name, "_done_pulses"}, 32'(nd), 32'(e.done));
      check({e.name, "_abort_pulses"}, 32'(na), 32'(e.abort));
    end
  endtask

  vec_t tv[6];

  initial begin
    int d0;
    int a0;

    tv[0] = '{1'b1, 8'hA5, 16, 32'h0000_14A0, 1, 0};
    tv[1] = '{1'b1, 8'h5A, 7,  32'h0000_0005, 0, 1};
    tv[2] = '{1'b0, 8'h00, 16, 32'h0000_0B40, 1, 0};
    tv[3] = '{1'b1, 8'hFF, 20, 32'h0001_FE00, 1, 0};
    tv[4] = '{1'b1, 8'h01, 16, 32'h0000_0020, 1, 0};
    tv[5] = '{1'b1, 8'h80, 16, 32'h0000_1000, 1, 0};

    rst          = 1'b0;
    cs           = 1'b1;
    scl          = 1'b0;
    sample       = '0;
    sample_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sdo", 32'(sdo), 32'd0);
    check("rst_sdo_oe", 32'(sdo_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_abort", 32'(frame_abort), 32'd0);
    check("rst_sample_ready", 32'(sample_ready), 32'd0);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;

`ifndef ALS_RESP_TEST_PATTERN_EN
    check("ready_after_reset", 32'(sample_ready), 32'd1);

    for (int i = 0; i < 6; i++) begin
      if (tv[i].offer) offer(tv[i].smp);
      do_frame($sformatf("vec%0d", i), tv[i].edges, -1, 8'h00,
               tv[i].exp_bits, tv[i].exp_done, tv[i].exp_abort);
    end

    // Sample arriving mid-frame lands in the following frame only.
    offer(8'hFF);
    do_frame("mid_current", 16, 5, 8'h3C, 32'h0000_1FE0, 1, 0);
    do_frame("mid_next", 16, -1, 8'h00, 32'h0000_0780, 1, 0);

    // Reset asserted after the ninth falling scl edge.
    offer(8'h77);
    d0 = done_seen;
    a0 = abort_seen;
    @(posedge clk); #1;
    cs = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      scl = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      scl = 1'b0;
      repeat (8) @(posedge clk);
      #1;
    end
    check("midrst_oe_before", 32'(sdo_oe), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_oe_in_reset", 32'(sdo_oe), 32'd0);
    check("midrst_busy_in_reset", 32'(busy), 32'd0);
    check("midrst_sdo_in_reset", 32'(sdo), 32'd0);
    check("midrst_ready_in_reset", 32'(sample_ready), 32'd0);
    cs  = 1'b1;
    scl = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_no_done", 32'(done_seen - d0), 32'd0);
    check("midrst_no_abort", 32'(abort_seen - a0), 32'd0);
    do_frame("post_rst", 16, -1, 8'h00, 32'h0000_0000, 1, 0);
`else
    check("pattern_ready_low", 32'(sample_ready), 32'd0);
    offer(8'hA5);
    check("pattern_ready_still_low", 32'(sample_ready), 32'd0);
    do_frame("pattern0", 16, -1, 8'h00, 32'h0000_0000, 1, 0);
    do_frame("pattern1", 16, -1, 8'h00, 32'h0000_0020, 1, 0);
    do_frame("pattern2", 16, -1, 8'h00, 32'h0000_0040, 1, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
